// File: rtl/fetch_if.sv
// Instruction-memory request bus: valid/addr out of fetch, one-cycle ready pulse with rdata back.
// No pipelining: a single request is outstanding at a time and addr is held until ready.
interface fetch_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] rdata;

  modport master (output valid, output addr, input ready, input rdata);
  modport slave  (input valid, input addr, output ready, output rdata);
endinterface

// File: rtl/fetch.sv
// Instruction fetch: presents imem response to decode 1 cycle after ready, one insn per ready.
// hlt holds outputs (a response arriving under hlt parks in a one-entry buffer); override redirects.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        override,
  input  logic [31:0] newpc,
  fetch_if.master     imem,
  output logic [31:0] insn,
  output logic [31:0] outpc,
  output logic        insn_valid,
  output logic        fault
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP, S_FAULT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] r_buf;
  logic [31:0] r_insn;
  logic [31:0] r_outpc;
  logic        r_insn_valid;
  logic        r_fault;
  logic        r_req;
  logic        r_pend_fault;

  logic        w_resp;
  logic        w_redir;
  logic        w_misal;
  logic        w_busy;
  logic [31:0] w_pc_inc;

  // A ready pulse only counts when a request is actually on the bus.
  assign w_resp   = imem.ready & r_req;
  assign w_busy   = r_req & ~imem.ready;
  assign w_redir  = override & ~hlt;
  assign w_misal  = w_redir & (newpc[1:0] != 2'b00);
  assign w_pc_inc = r_pc + 32'd4;

  assign imem.valid = r_req;
  assign imem.addr  = {r_pc[31:2], 2'b00};
  assign insn       = r_insn;
  assign outpc      = r_outpc;
  assign insn_valid = r_insn_valid;
  assign fault      = r_fault;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_tgt        <= RESET_PC;
      r_buf        <= NOP;
      r_insn       <= NOP;
      r_outpc      <= RESET_PC;
      r_insn_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_req        <= 1'b0;
      r_pend_fault <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_redir) begin
            r_insn_valid <= 1'b0;
            r_insn       <= NOP;
            if (w_misal) begin
              r_fault <= 1'b1;
              if (w_busy) begin
                r_state      <= S_DROP;
                r_pend_fault <= 1'b1;
              end else begin
                r_state <= S_FAULT;
                r_req   <= 1'b0;
              end
            end else if (w_busy) begin
              r_state      <= S_DROP;
              r_tgt        <= newpc;
              r_pend_fault <= 1'b0;
            end else begin
              r_pc  <= newpc;
              r_req <= 1'b1;
            end
          end else if (hlt) begin
            if (w_resp) begin
              r_buf   <= imem.rdata;
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end else begin
              r_req <= 1'b1;
            end
          end else begin
            r_req <= 1'b1;
            if (w_resp) begin
              r_insn       <= imem.rdata;
              r_outpc      <= r_pc;
              r_insn_valid <= 1'b1;
              r_pc         <= w_pc_inc;
            end else begin
              r_insn_valid <= 1'b0;
              r_insn       <= NOP;
            end
          end
        end

        S_HOLD: begin
          if (w_redir) begin
            r_insn_valid <= 1'b0;
            r_insn       <= NOP;
            if (w_misal) begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end else begin
              r_pc    <= newpc;
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end
          end else if (!hlt) begin
            r_insn       <= r_buf;
            r_outpc      <= r_pc;
            r_insn_valid <= 1'b1;
            r_pc         <= w_pc_inc;
            r_state      <= S_FETCH;
            r_req        <= 1'b1;
          end
        end

        S_DROP: begin
          if (w_misal) begin
            r_fault      <= 1'b1;
            r_pend_fault <= 1'b1;
          end else if (w_redir) begin
            r_tgt <= newpc;
          end
          // Old address stays on the bus until its response is swallowed.
          if (w_resp) begin
            if (r_pend_fault || w_misal) begin
              r_state <= S_FAULT;
              r_req   <= 1'b0;
            end else begin
              r_state <= S_FETCH;
              r_pc    <= w_redir ? newpc : r_tgt;
            end
          end
        end

        S_FAULT: begin
          r_req        <= 1'b0;
          r_insn_valid <= 1'b0;
          r_fault      <= 1'b1;
        end

        default: r_state <= S_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: reset, straight-line, back-to-back, stall, redirects, fault, pc wrap.
module tb_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        hlt;
  logic        override;
  logic [31:0] newpc;
  logic [31:0] insn;
  logic [31:0] outpc;
  logic        insn_valid;
  logic        fault;
  logic [31:0] w_insn;
  logic [31:0] w_outpc;
  logic        w_insn_valid;
  logic        w_fault;
  logic        w_hlt;
  logic        w_override;
  logic [31:0] w_newpc;

  int checks;
  int errors;

  fetch_if bus ();
  fetch_if wbus ();

  fetch u_dut (
    .clk(clk), .rst(rst), .hlt(hlt), .override(override), .newpc(newpc),
    .imem(bus), .insn(insn), .outpc(outpc), .insn_valid(insn_valid), .fault(fault)
  );

  fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .hlt(w_hlt), .override(w_override), .newpc(w_newpc),
    .imem(wbus), .insn(w_insn), .outpc(w_outpc), .insn_valid(w_insn_valid), .fault(w_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; hlt = 1'b0; override = 1'b0; newpc = 32'h0;
    bus.ready = 1'b0; bus.rdata = 32'h0; wbus.ready = 1'b0; wbus.rdata = 32'h0;
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic respond(input int waits, input logic [31:0] data);
    bus.ready = 1'b0;
    repeat (waits) tick;
    bus.ready = 1'b1; bus.rdata = data;
    tick;
    bus.ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; hlt = 1'b0; override = 1'b0; newpc = 32'h0;
    w_hlt = 1'b0; w_override = 1'b0; w_newpc = 32'h0;
    bus.ready = 1'b1; bus.rdata = 32'hDEAD_BEEF; wbus.ready = 1'b0; wbus.rdata = 32'h0;
    tick; tick;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.valid); end
    checks++; if (insn !== NOP) begin errors++; $display("FAIL rst_insn got %h want %h", insn, NOP); end
    checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL rst_insn_valid got %b want 0", insn_valid); end
    checks++; if (outpc !== 32'h0) begin errors++; $display("FAIL rst_outpc got %h want 0", outpc); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fault); end
    bus.ready = 1'b0; rst = 1'b1;
    tick;
    checks++; if (bus.valid !== 1'b1 || bus.addr !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h want 1/0", bus.valid, bus.addr); end
    respond(1, mdata(32'h0));
    // Asynchronous reset mid-transaction with ready asserted during reset.
    bus.ready = 1'b1; bus.rdata = mdata(32'h4); rst = 1'b0;
    #1;
    checks++; if (insn_valid !== 1'b0 || bus.valid !== 1'b0) begin errors++; $display("FAIL async_rst got %b/%b want 0/0", insn_valid, bus.valid); end
    tick;
    rst = 1'b1; bus.ready = 1'b0;
    tick;
    checks++; if (bus.addr !== 32'h0 || bus.valid !== 1'b1) begin errors++; $display("FAIL rerun_addr got %h/%b want 0/1", bus.addr, bus.valid); end
    checks++; if (insn_valid !== 1'b0) begin errors++; $display("FAIL rerun_iv got %b want 0", insn_valid); end
    respond(1, mdata(32'h0));
    checks++; if (outpc !== 32'h0 || insn !== mdata(32'h0)) begin errors++; $display("FAIL rerun_insn got %h/%h want 0/%h", outpc, insn, mdata(32'h0)); end
  endtask

  task automatic test_straight;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = 32'(4 * k);
      checks++; if (bus.addr !== a || bus.valid !== 1'b1) begin errors++; $display("FAIL line_addr%0d got %h want %h", k, bus.addr, a); end
      respond(1, mdata(a));
      checks++; if (insn_valid !== 1'b1 || outpc !== a || insn !== mdata(a)) begin errors++; $display("FAIL line_out%0d got %b/%h/%h want 1/%h/%h", k, insn_valid, outpc, insn, a, mdata(a)); end
    end
  endtask

  task automatic test_back_to_back;
    bus.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a;
      a = 32'(12 + 4 * k);
      checks++; if (bus.addr !== a) begin errors++; $display("FAIL b2b_addr%0d got %h want %h", k, bus.addr, a); end
      bus.rdata = mdata(a);
      tick;
      checks++; if (insn_valid !== 1'b1 || outpc !== a || insn !== mdata(a)) begin errors++; $display("FAIL b2b_out%0d got %b/%h/%h want 1/%h/%h", k, insn_valid, outpc, insn, a, mdata(a)); end
    end
    bus.ready = 1'b0;
    tick;
    checks++; if (insn_valid !== 1'b0 || insn !== NOP) begin errors++; $display("FAIL bubble got %b/%h want 0/%h", insn_valid, insn, NOP); end
  endtask

  task automatic test_stall;
    do_reset;
    respond(1, mdata(32'h0));
    respond(1, mdata(32'h4));
    checks++; if (bus.addr !== 32'h8) begin errors++; $display("FAIL stall_addr got %h want 8", bus.addr); end
    hlt = 1'b1; bus.ready = 1'b1; bus.rdata = 32'h0050_0093;
    tick;
    bus.ready = 1'b0;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL hold_valid got %b want 0", bus.valid); end
    checks++; if (insn_valid !== 1'b1 || outpc !== 32'h4 || insn !== mdata(32'h4)) begin errors++; $display("FAIL hold_out got %b/%h/%h want 1/4/%h", insn_valid, outpc, insn, mdata(32'h4)); end
    tick;
    checks++; if (bus.valid !== 1'b0 || outpc !== 32'h4) begin errors++; $display("FAIL hold2 got %b/%h want 0/4", bus.valid, outpc); end
    hlt = 1'b0;
    tick;
    checks++; if (insn !== 32'h0050_0093 || outpc !== 32'h8 || insn_valid !== 1'b1) begin errors++; $display("FAIL unstall got %h/%h/%b want 00500093/8/1", insn, outpc, insn_valid); end
    checks++; if (bus.valid !== 1'b1 || bus.addr !== 32'hC) begin errors++; $display("FAIL unstall_addr got %b/%h want 1/c", bus.valid, bus.addr); end
  endtask

  task automatic test_redirect;
    do_reset;
    respond(1, mdata(32'h0));
    bus.ready = 1'b0;
    tick;
    override = 1'b1; newpc = 32'h100;
    tick;
    override = 1'b0;
    checks++; if (bus.valid !== 1'b1 || bus.addr !== 32'h4 || insn_valid !== 1'b0) begin errors++; $display("FAIL drop_bus got %b/%h/%b want 1/4/0", bus.valid, bus.addr, insn_valid); end
    tick; tick;
    bus.ready = 1'b1; bus.rdata = mdata(32'h4);
    tick;
    bus.ready = 1'b0;
    checks++; if (insn_valid !== 1'b0 || bus.addr !== 32'h100 || bus.valid !== 1'b1) begin errors++; $display("FAIL drop_done got %b/%h/%b want 0/100/1", insn_valid, bus.addr, bus.valid); end
    respond(1, mdata(32'h100));
    checks++; if (insn_valid !== 1'b1 || outpc !== 32'h100 || insn !== mdata(32'h100)) begin errors++; $display("FAIL redir_out got %b/%h/%h want 1/100/%h", insn_valid, outpc, insn, mdata(32'h100)); end
  endtask

  task automatic test_same_cycle;
    bus.ready = 1'b1; bus.rdata = mdata(32'h104); override = 1'b1; newpc = 32'h40;
    tick;
    bus.ready = 1'b0; override = 1'b0;
    checks++; if (insn_valid !== 1'b0 || insn !== NOP) begin errors++; $display("FAIL same_out got %b/%h want 0/%h", insn_valid, insn, NOP); end
    checks++; if (bus.addr !== 32'h40 || bus.valid !== 1'b1) begin errors++; $display("FAIL same_addr got %h/%b want 40/1", bus.addr, bus.valid); end
    respond(0, mdata(32'h40));
    checks++; if (outpc !== 32'h40 || insn !== mdata(32'h40)) begin errors++; $display("FAIL same_next got %h/%h want 40/%h", outpc, insn, mdata(32'h40)); end
  endtask

  task automatic test_override_hlt;
    hlt = 1'b1; override = 1'b1; newpc = 32'h80;
    tick;
    hlt = 1'b0; override = 1'b0;
    checks++; if (bus.addr !== 32'h44 || insn_valid !== 1'b1 || outpc !== 32'h40) begin errors++; $display("FAIL ovr_hlt got %h/%b/%h want 44/1/40", bus.addr, insn_valid, outpc); end
  endtask

  task automatic test_misaligned;
    override = 1'b1; newpc = 32'h102;
    tick;
    override = 1'b0;
    checks++; if (fault !== 1'b1 || bus.valid !== 1'b1 || bus.addr !== 32'h44 || insn_valid !== 1'b0) begin errors++; $display("FAIL mis_drop got %b/%b/%h/%b want 1/1/44/0", fault, bus.valid, bus.addr, insn_valid); end
    bus.ready = 1'b1; bus.rdata = mdata(32'h44);
    tick;
    bus.ready = 1'b0;
    checks++; if (bus.valid !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL mis_fault got %b/%b want 0/1", bus.valid, fault); end
    override = 1'b1; newpc = 32'h200;
    repeat (4) tick;
    override = 1'b0;
    checks++; if (bus.valid !== 1'b0 || fault !== 1'b1 || insn_valid !== 1'b0) begin errors++; $display("FAIL mis_sticky got %b/%b/%b want 0/1/0", bus.valid, fault, insn_valid); end
    rst = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || outpc !== 32'h0) begin errors++; $display("FAIL mis_rst got %b/%h want 0/0", fault, outpc); end
    tick;
    rst = 1'b1;
    tick;
    checks++; if (bus.valid !== 1'b1 || bus.addr !== 32'h0) begin errors++; $display("FAIL mis_refetch got %b/%h want 1/0", bus.valid, bus.addr); end
  endtask

  task automatic test_wrap;
    do_reset;
    checks++; if (wbus.addr !== 32'hFFFF_FFFC || wbus.valid !== 1'b1) begin errors++; $display("FAIL wrap_first got %h/%b want fffffffc/1", wbus.addr, wbus.valid); end
    wbus.ready = 1'b1; wbus.rdata = 32'h0000_0011;
    tick;
    wbus.ready = 1'b0;
    checks++; if (w_outpc !== 32'hFFFF_FFFC || w_insn_valid !== 1'b1 || w_insn !== 32'h11) begin errors++; $display("FAIL wrap_out got %h/%b/%h want fffffffc/1/11", w_outpc, w_insn_valid, w_insn); end
    checks++; if (wbus.addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", wbus.addr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_straight;
    test_back_to_back;
    test_stall;
    test_redirect;
    test_same_cycle;
    test_override_hlt;
    test_misaligned;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Parameters
REQ-001 RESET_PC, 32'h00000000, address of the first fetch after reset.
REQ-002 NOP, 32'h00000013, instruction word driven while no valid instruction is presented.

Interface
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; asynchronous assert, active-low (0 = reset).
REQ-005 hlt  in  1  downstream stall; while 1, presented outputs are held.
REQ-006 override  in  1  redirect request from execute.
REQ-007 newpc  in  32  redirect target, valid with override.
REQ-008 imem_valid  out  1  instruction memory request.
REQ-009 imem_ready  in  1  one-cycle response pulse; imem_rdata is valid in the same cycle.
REQ-010 imem_addr  out  32  word-aligned fetch address.
REQ-011 imem_rdata  in  32  fetched instruction word.
REQ-012 insn  out  32  instruction presented to decode.
REQ-013 outpc  out  32  PC of insn (execute inpc).
REQ-014 insn_valid  out  1  insn/outpc are a real instruction.
REQ-015 fault  out  1  sticky misaligned-redirect flag.

Function
REQ-016 Internal pc register; imem_addr SHALL equal {pc[31:2],2'b00}.
REQ-017 FSM states: FETCH, HOLD, DROP, FAULT.
REQ-018 FETCH: imem_valid=1; imem_addr SHALL remain stable until imem_ready.
REQ-019 FETCH, imem_ready=1, hlt=0, override=0: insn<=imem_rdata, outpc<=pc, insn_valid<=1, pc<=pc+4 (mod 2^32), stay in FETCH.
REQ-020 FETCH, imem_ready=1, hlt=1: imem_rdata and pc SHALL be captured into a one-entry buffer; go to HOLD; outputs stay unchanged.
REQ-021 HOLD: imem_valid=0; when hlt=0, load the buffer into insn/outpc, set insn_valid<=1, pc<=pc+4, go to FETCH.
REQ-022 In FETCH, when hlt=0 and no response completes this cycle, insn_valid<=0 and insn<=NOP.
REQ-023 override with hlt=0 and newpc[1:0]==0: pc<=newpc; insn_valid<=0 and insn<=NOP; HOLD buffer discarded.
REQ-024 override while a request is outstanding and imem_ready=0: go to DROP.
REQ-025 override in the same cycle as imem_ready: discard the data; go to FETCH at newpc.
REQ-026 DROP: imem_valid=1 at the old address until imem_ready; discard the response; go to FETCH; no output update.
REQ-027 override while in DROP: pc<=newpc (last redirect wins); remain in DROP.
REQ-028 override with hlt=1 SHALL be ignored.
REQ-029 override, hlt=0, newpc[1:0]!=0: fault<=1; go to FAULT (via DROP if a request is outstanding); insn_valid<=0.
REQ-030 FAULT: imem_valid=0, insn_valid=0, fault=1 until reset.
REQ-031 pc+4 SHALL wrap from 32'hFFFFFFFC to 32'h00000000.
REQ-032 Request to presented output latency: 1 cycle after imem_ready.
REQ-033 Throughput: one instruction per imem_ready, with no bubble inserted by fetch.

Reset
REQ-034 rst=0 SHALL asynchronously force: pc=RESET_PC, outpc=RESET_PC, insn=NOP, insn_valid=0, fault=0, buffer empty, state FETCH.
REQ-035 imem_valid SHALL be 0 while rst=0.
REQ-036 Reset mid-transaction SHALL abandon the request; the first request after release is to RESET_PC.
REQ-037 imem_ready received during reset SHALL be ignored.

Verification
REQ-038 Straight line: release reset, memory with ready one cycle after valid -> addresses 0,4,8; outpc 0,4,8 with insn matching the memory contents.
REQ-039 Stall: hlt=1 when imem_ready returns 32'h00500093 at pc 8 -> HOLD, imem_valid=0; hlt=0 -> insn=32'h00500093, outpc=8, next address 12.
REQ-040 Redirect in flight: override with newpc=32'h00000100 while the pc-4 request waits 3 cycles -> the pc-4 data is discarded; next address 0x100; insn_valid=0 until the 0x100 response.
REQ-041 Same-cycle: override (newpc=0x40) coincident with imem_ready -> data dropped; next imem_addr=0x40.
REQ-042 Misaligned: override with newpc=32'h00000102 -> fault=1, imem_valid=0 persistently; rst=0 -> fault=0, fetch at RESET_PC.
REQ-043 Wrap: RESET_PC=32'hFFFFFFFC -> second fetch address is 32'h00000000.
